mips32_wb_arbiter: RTL



---
 rtl/mips32_wb_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mips32_wb_arbiter.sv
// N-master to 1-slave Wishbone B3 arbiter for the I-cache/D-cache/DMA buses.
// Fixed-priority or round-robin grant, ownership held for the whole CYC, hung-cycle watchdog.
module mips32_wb_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ARB_MODE    = 0,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                                  CLK_I,
  input  logic                                  RST_N_I,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     M_ADR_I,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     M_DAT_I,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] M_SEL_I,
  input  logic [NUM_MASTERS-1:0]                M_CYC_I,
  input  logic [NUM_MASTERS-1:0]                M_STB_I,
  input  logic [NUM_MASTERS-1:0]                M_WE_I,
  input  logic [NUM_MASTERS-1:0]                M_LOCK_I,
  input  logic [NUM_MASTERS*3-1:0]              M_CTI_I,
  input  logic [NUM_MASTERS*2-1:0]              M_BTE_I,
  output logic [NUM_MASTERS-1:0]                M_ACK_O,
  output logic [NUM_MASTERS-1:0]                M_ERR_O,
  output logic [NUM_MASTERS-1:0]                M_RTY_O,
  output logic [DATA_WIDTH-1:0]                 M_DAT_O,
  output logic [ADDR_WIDTH-1:0]                 S_ADR_O,
  output logic [DATA_WIDTH-1:0]                 S_DAT_O,
  output logic [DATA_WIDTH/8-1:0]               S_SEL_O,
  output logic                                  S_CYC_O,
  output logic                                  S_STB_O,
  output logic                                  S_WE_O,
  output logic                                  S_LOCK_O,
  output logic [2:0]                            S_CTI_O,
  output logic [1:0]                            S_BTE_O,
  input  logic                                  S_ACK_I,
  input  logic                                  S_ERR_I,
  input  logic                                  S_RTY_I,
  input  logic [DATA_WIDTH-1:0]                 S_DAT_I,
  output logic [NUM_MASTERS-1:0]                GRANT_O
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state;
  logic [NUM_MASTERS-1:0] grant;
  logic [PTR_WIDTH-1:0]   rr_ptr;
  logic [CNT_WIDTH-1:0]   wd_cnt;

  logic [NUM_MASTERS-1:0] rr_mask;
  logic [NUM_MASTERS-1:0] search;
  logic [NUM_MASTERS-1:0] win_oh;
  logic [PTR_WIDTH-1:0]   win_idx;
  logic                   win_valid;
  logic                   owner_cyc;
  logic                   term;
  logic                   timeout_err;

  // Round-robin: prefer requesters above the last owner, else wrap to the lowest index.
  always_comb begin
    rr_mask = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      rr_mask[i] = (i > 32'(rr_ptr));
    end
  end

  always_comb begin
    search    = M_CYC_I;
    win_valid = 1'b0;
    win_oh    = '0;
    win_idx   = '0;
    if ((ARB_MODE != 0) && (|(M_CYC_I & rr_mask))) begin
      search = M_CYC_I & rr_mask;
    end
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (search[i] && !win_valid) begin
        win_valid  = 1'b1;
        win_oh[i]  = 1'b1;
        win_idx    = PTR_WIDTH'(i);
      end
    end
  end

  assign owner_cyc = |(grant & M_CYC_I);

  // Grant is one-hot, so an OR of the gated slices is the owner mux.
  always_comb begin
    S_ADR_O  = '0;
    S_DAT_O  = '0;
    S_SEL_O  = '0;
    S_CYC_O  = 1'b0;
    S_STB_O  = 1'b0;
    S_WE_O   = 1'b0;
    S_LOCK_O = 1'b0;
    S_CTI_O  = '0;
    S_BTE_O  = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i] && M_CYC_I[i]) begin
        S_ADR_O  = S_ADR_O | M_ADR_I[i*ADDR_WIDTH +: ADDR_WIDTH];
        S_DAT_O  = S_DAT_O | M_DAT_I[i*DATA_WIDTH +: DATA_WIDTH];
        S_SEL_O  = S_SEL_O | M_SEL_I[i*SEL_WIDTH +: SEL_WIDTH];
        S_CYC_O  = 1'b1;
        S_STB_O  = S_STB_O | M_STB_I[i];
        S_WE_O   = S_WE_O | M_WE_I[i];
        S_LOCK_O = S_LOCK_O | M_LOCK_I[i];
        S_CTI_O  = S_CTI_O | M_CTI_I[i*3 +: 3];
        S_BTE_O  = S_BTE_O | M_BTE_I[i*2 +: 2];
      end
    end
  end

  assign term        = S_ACK_I | S_ERR_I | S_RTY_I;
  // A real slave termination in the expiry cycle suppresses the forced ERR.
  assign timeout_err = (TIMEOUT != 0) && S_STB_O && !term && (wd_cnt == CNT_WIDTH'(TIMEOUT));

  assign M_ACK_O = grant & {NUM_MASTERS{S_ACK_I}};
  assign M_RTY_O = grant & {NUM_MASTERS{S_RTY_I}};
  assign M_ERR_O = grant & {NUM_MASTERS{S_ERR_I | timeout_err}};
  assign M_DAT_O = (|grant) ? S_DAT_I : '0;
  assign GRANT_O = grant;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= PTR_WIDTH'(NUM_MASTERS - 1);
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (win_valid) begin
            grant  <= win_oh;
            rr_ptr <= win_idx;
            state  <= OWNED;
          end
        end
        OWNED: begin
          if (!owner_cyc) begin
            grant  <= '0;
            wd_cnt <= '0;
            state  <= IDLE;
          end else if ((TIMEOUT != 0) && S_STB_O && !term && !timeout_err) begin
            wd_cnt <= wd_cnt + 1'b1;
          end else begin
            wd_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
